// File: rtl/biquad8_coeff_sequencer_if.sv
// WISHBONE master bus bundle used by the biquad8 coefficient sequencer.
interface biquad8_coeff_sequencer_if #(
    parameter int unsigned ADR_W = 11
);
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_we_o;
    logic [ADR_W-1:0] wb_adr_o;
    logic [31:0]      wb_dat_o;
    logic [3:0]       wb_sel_o;
    logic             wb_ack_i;
    logic             wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/biquad8_coeff_sequencer.sv
// Loads coefficient sets from a local RAM into biquad8 channels over WISHBONE, then commits.
// Optional ack watchdog enabled by defining BIQUAD_SEQ_TIMEOUT_EN.
module biquad8_coeff_sequencer #(
    parameter int unsigned NCHAN     = 16,
    parameter int unsigned CHAN_BITS = 4,
    parameter int unsigned N_FIR     = 2,
    parameter int unsigned N_PF      = 2,
    parameter int unsigned N_IIR     = 4,
    parameter int unsigned N_INC     = 8,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned WPC       = N_FIR + 4 * N_PF + N_IIR + N_INC,
    localparam int unsigned CADR_BITS = $clog2(NCHAN * WPC)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   start_i,
    input  logic [NCHAN-1:0]       chan_mask_i,
    input  logic                   sync_update_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   global_update_o,
    output logic                   coeff_rd_o,
    output logic [CADR_BITS-1:0]   coeff_adr_o,
    input  logic [17:0]            coeff_dat_i,
    biquad8_coeff_sequencer_if.master wb
);

    localparam int unsigned WORD_W = $clog2(WPC + 1);
    localparam int unsigned ADR_W  = CHAN_BITS + 7;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_FETCH, S_WAIT, S_WRITE, S_UPD, S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [NCHAN-1:0]       mask_q, mask_d;
    logic                   sync_q, sync_d;
    logic [CHAN_BITS-1:0]   chan_q, chan_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, glob_q, glob_d;
    logic                   rd_q, rd_d;
    logic [CADR_BITS-1:0]   cadr_q, cadr_d;
    logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADR_W-1:0]       adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic [3:0]             sel_q, sel_d;

    logic [CHAN_BITS-1:0]   low_chan_c;
    logic [6:0]             reg_c;
    logic                   timeout_c;
    logic                   bus_err_c;

    function automatic logic [CADR_BITS-1:0] cadr_of(input logic [CHAN_BITS-1:0] ch,
                                                     input logic [WORD_W-1:0]    w);
        return CADR_BITS'(ch * WPC) + CADR_BITS'(w);
    endfunction

    // Lowest pending channel, so channels are served in ascending order
    always_comb begin
        low_chan_c = '0;
        for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
            if (mask_q[i]) low_chan_c = CHAN_BITS'(i);
        end
    end

    always_comb begin
        if (word_q < WORD_W'(N_FIR))                    reg_c = 7'h04;
        else if (word_q < WORD_W'(N_FIR + N_PF))        reg_c = 7'h10;
        else if (word_q < WORD_W'(N_FIR + 2 * N_PF))    reg_c = 7'h14;
        else if (word_q < WORD_W'(N_FIR + 3 * N_PF))    reg_c = 7'h18;
        else if (word_q < WORD_W'(N_FIR + 4 * N_PF))    reg_c = 7'h1C;
        else if (word_q < WORD_W'(WPC - N_INC))         reg_c = 7'h08;
        else                                            reg_c = 7'h0C;
    end

`ifdef BIQUAD_SEQ_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (stb_d && !stb_q)
            to_cnt_d = '0;
        else if (stb_q && !wb.wb_ack_i && !wb.wb_err_i)
            to_cnt_d = to_cnt_q + 8'd1;
    end

    assign timeout_c = stb_q && !wb.wb_ack_i && (to_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) to_cnt_q <= '0;
        else            to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Error wins over a simultaneous ack
    assign bus_err_c = stb_q && (wb.wb_err_i || timeout_c);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sync_d  = sync_q;
        chan_d  = chan_q;
        word_d  = word_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        glob_d  = 1'b0;
        rd_d    = 1'b0;
        cadr_d  = cadr_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (|chan_mask_i) begin
                        mask_d  = chan_mask_i;
                        sync_d  = sync_update_i;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    done_d  = 1'b1;
                    glob_d  = sync_q;
                    state_d = S_FIN;
                end else begin
                    chan_d  = low_chan_c;
                    mask_d  = mask_q & ~(NCHAN'(1) << low_chan_c);
                    word_d  = '0;
                    rd_d    = 1'b1;
                    cadr_d  = cadr_of(low_chan_c, '0);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                dat_d   = {14'b0, coeff_dat_i};
                sel_d   = 4'hF;
                adr_d   = {chan_q, reg_c};
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE, S_UPD: begin
                if (state_q == S_UPD && !stb_q) begin
                    adr_d = {chan_q, 7'h00};
                    dat_d = 32'h1;
                    sel_d = 4'h1;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                end else if (bus_err_c) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    mask_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (wb.wb_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (state_q == S_UPD) begin
                        state_d = S_SCAN;
                    end else begin
                        word_d = word_q + WORD_W'(1);
                        if (word_q == WORD_W'(WPC - 1)) begin
                            state_d = sync_q ? S_SCAN : S_UPD;
                        end else begin
                            rd_d    = 1'b1;
                            cadr_d  = cadr_of(chan_q, word_q + WORD_W'(1));
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            sync_q  <= 1'b0;
            chan_q  <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            glob_q  <= 1'b0;
            rd_q    <= 1'b0;
            cadr_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sync_q  <= sync_d;
            chan_q  <= chan_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            glob_q  <= glob_d;
            rd_q    <= rd_d;
            cadr_q  <= cadr_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign global_update_o = glob_q;
    assign coeff_rd_o      = rd_q;
    assign coeff_adr_o     = cadr_q;
    assign wb.wb_cyc_o     = cyc_q;
    assign wb.wb_stb_o     = stb_q;
    assign wb.wb_we_o      = we_q;
    assign wb.wb_adr_o     = adr_q;
    assign wb.wb_dat_o     = dat_q;
    assign wb.wb_sel_o     = sel_q;

endmodule
